// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
// External data-bus bundle between the data-memory controller and memory.
//   mem_req    controller -> memory : bus request
//   mem_we     controller -> memory : 1 = write
//   mem_addr   controller -> memory : word address
//   mem_be     controller -> memory : byte enables
//   mem_wdata  controller -> memory : lane-replicated store data
//   mem_gnt    memory -> controller : request accepted
//   mem_rvalid memory -> controller : mem_rdata valid
//   mem_rdata  memory -> controller : read word
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [3:0]   mem_be;
    logic [W-1:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory bus controller behind the memory stage. Converts a load/store
// request into a req/gnt/rvalid bus transaction, steers store byte lanes,
// returns aligned sign/zero-extended load data and stalls the pipeline until
// the access completes.
//   clk, rst   clock, asynchronous active-high reset
//   opType     2'b10 load, 2'b01 store, otherwise none
//   width      funct3 access size (B/H/W/BU/HU)
//   data_addr  byte address
//   data_out   store data
//   data_in    extended load result
//   stall      pipeline hold
//   misalign   illegal/misaligned access flag (no bus access made)
//   bus_err    one-cycle pulse on timeout abort
//   mem        external data bus (dmem_ctrl_if.master)
// Optional feature: define DMEM_TIMEOUT_EN to abort bus waits after TIMEOUT
// cycles; otherwise the controller waits indefinitely and bus_err is 0.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   opType,
    input  logic [2:0]   width,
    input  logic [W-1:0] data_addr,
    input  logic [W-1:0] data_out,
    output logic [W-1:0] data_in,
    output logic         stall,
    output logic         misalign,
    output logic         bus_err,
    dmem_ctrl_if.master  mem
);

    if (W != 32) begin : g_bad_w
        $error("dmem_ctrl supports only W = 32");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dmem_ctrl TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_we;
    logic [W-1:0] r_addr;
    logic [3:0]   r_be;
    logic [W-1:0] r_wdata;
    logic [1:0]   r_off;
    logic [2:0]   r_width;
    logic [W-1:0] r_load_q;

    logic         w_is_ld;
    logic         w_is_st;
    logic         w_bad_width;
    logic         w_misal;
    logic         w_illegal;
    logic         w_start;
    logic [3:0]   w_be;
    logic [W-1:0] w_wdata;
    logic [W-1:0] w_shifted;
    logic [W-1:0] w_load;
    logic         w_finish;
    logic         w_capture;
    logic         w_timeout;
    logic         w_abort;

    assign w_is_ld = (opType == 2'b10);
    assign w_is_st = (opType == 2'b01);

    always_comb begin
        w_bad_width = 1'b0;
        w_misal     = 1'b0;
        case (width)
            3'b000, 3'b100: w_misal = 1'b0;
            3'b001, 3'b101: w_misal = data_addr[0];
            3'b010:         w_misal = |data_addr[1:0];
            default:        w_bad_width = 1'b1;
        endcase
    end

    // Unsigned widths have no store form, so width[2] on a store is illegal.
    assign w_illegal = (w_is_ld || w_is_st) && (w_bad_width || w_misal || (w_is_st && width[2]));
    assign w_start   = (w_is_ld || w_is_st) && !w_illegal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = data_out;
        case (width[1:0])
            2'b00: begin
                w_be    = 4'b0001 << data_addr[1:0];
                w_wdata = {4{data_out[7:0]}};
            end
            2'b01: begin
                w_be    = data_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_out[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = data_out;
            end
        endcase
    end

    assign w_shifted = mem.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_width)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {{24{1'b0}}, w_shifted[7:0]};
            3'b101:  w_load = {{16{1'b0}}, w_shifted[15:0]};
            default: w_load = mem.mem_rdata;
        endcase
    end

    // A completing handshake always wins over a timeout in the same cycle.
    assign w_finish  = ((r_state == REQ) && mem.mem_gnt && (r_we || mem.mem_rvalid)) ||
                       ((r_state == WAIT_R) && mem.mem_rvalid);
    assign w_capture = w_finish && !r_we;
    assign w_abort   = w_timeout && !w_finish;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_bus_err;

    assign w_timeout = ((r_state == REQ) || (r_state == WAIT_R)) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if ((r_state == IDLE) && w_start) begin
                r_cnt <= '0;
            end else if ((r_state == REQ) || (r_state == WAIT_R)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = REQ;
            end
            REQ: begin
                if (w_finish || w_abort) w_next = DONE;
                else if (mem.mem_gnt)    w_next = WAIT_R;
            end
            WAIT_R: begin
                if (w_finish || w_abort) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_off    <= '0;
            r_width  <= '0;
            r_load_q <= '0;
        end else begin
            if ((r_state == IDLE) && w_start) begin
                r_we    <= w_is_st;
                r_addr  <= {data_addr[W-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_off   <= data_addr[1:0];
                r_width <= width;
            end
            if (w_capture) begin
                r_load_q <= w_load;
            end else if (w_abort) begin
                r_load_q <= '0;
            end
        end
    end

    assign mem.mem_req   = (r_state == REQ);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;

    assign stall    = !rst && (((r_state == IDLE) && w_start) || (r_state == REQ) || (r_state == WAIT_R));
    assign misalign = !rst && (r_state == IDLE) && w_illegal;
    assign data_in  = misalign ? '0 : r_load_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Scoreboard bench for dmem_ctrl: the driver computes expected bus requests
// and completion results from the access rules and queues them; a monitor
// compares them whenever the DUT presents a bus request or completes/rejects
// an access. The bench plays the memory side with random grant/rvalid delays.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam int TO = 16;
`ifdef DMEM_TIMEOUT_EN
    localparam int TO_LIMIT = TO;
`else
    localparam int TO_LIMIT = 1000000;
`endif
    localparam logic [1:0] OP_LD   = 2'b10;
    localparam logic [1:0] OP_ST   = 2'b01;
    localparam logic [1:0] OP_NONE = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  opType;
    logic [2:0]  width;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    dmem_ctrl_if #(.W(32)) bus ();

    dmem_ctrl #(.W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .opType    (opType),
        .width     (width),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        chk_be;
        int          req_cycles;
    } bus_t;

    typedef struct {
        logic        mis;
        logic [31:0] data;
        logic        berr;
        int          stalls;
        logic        pop_bus;
    } res_t;

    bus_t        bus_q[$];
    res_t        res_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_q = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int unsigned ref_size(input logic [2:0] w);
        case (w % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [1:0] op, input logic [2:0] w, input logic [31:0] a);
        if (w == 3 || w == 6 || w == 7) return 0;
        if (op == OP_ST && w >= 4) return 0;
        return (a % ref_size(w)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] w, input logic [31:0] a);
        int unsigned m;
        m = ((1 << ref_size(w)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] w, input logic [31:0] d);
        case (ref_size(w))
            1:       return (d % 256) * 32'h0101_0101;
            2:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] rd);
        int unsigned lane, b, h;
        lane = rd >> ((a % 4) * 8);
        b = lane % 256;
        h = lane % 65536;
        case (w)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // ---------------- driver / memory responder ----------------
    task automatic run_op(input logic [1:0] op, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d, input int gd, input int rd, input logic [31:0] rdata);
        bus_t b;
        res_t r;
        int   reqc, waitc, busy, cyc;
        bit   granted;
        r.mis = !ref_legal(op, w, a);
        r.berr = 1'b0;
        r.pop_bus = 1'b0;
        r.data = '0;
        r.stalls = 0;
        if (!r.mis) begin
            reqc  = gd + 1;
            waitc = (op == OP_LD && rd > 0) ? rd : 0;
            busy  = reqc + waitc;
            b.addr = a & ~32'h3;
            b.we = (op == OP_ST);
            b.be = ref_be(w, a);
            b.wdata = ref_wdata(w, d);
            b.chk_be = b.we || (w == 3'b010);
            b.req_cycles = reqc;
            if (busy > TO_LIMIT) begin
                r.berr = 1'b1;
                r.stalls = TO_LIMIT + 1;
                model_q = '0;
                if (reqc > TO_LIMIT) begin
                    r.pop_bus = 1'b1;
                    b.req_cycles = TO_LIMIT;
                end
            end else begin
                r.stalls = 1 + busy;
                if (op == OP_LD) model_q = ref_load(w, a, rdata);
            end
            r.data = model_q;
            bus_q.push_back(b);
        end
        res_q.push_back(r);

        @(negedge clk);
        opType = op; width = w; data_addr = a; data_out = d;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
        reqc = 0; waitc = 0; cyc = 0; granted = 0;
        #1;
        while (stall && cyc < 100) begin
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.mem_req) begin
                if (reqc >= gd) begin
                    bus.mem_gnt = 1'b1;
                    granted = 1;
                    if (op == OP_LD && rd == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = rdata;
                    end else if (op == OP_ST) begin
                        bus.mem_rvalid = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = $urandom;
                end
                reqc++;
            end else if (granted) begin
                waitc++;
                if (waitc >= rd) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            #1;
            cyc++;
        end
        if (cyc >= 100) chk("op_completes", 32'(stall), 32'd0);
        // stray rvalid in the completion cycle must be ignored
        if ($urandom_range(0, 2) == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = $urandom;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        opType = ($urandom_range(0, 1) == 0) ? OP_NONE : 2'b11;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_misalign", 32'(misalign), 32'd0);
        chk("idle_bus_err", 32'(bus_err), 32'd0);
        chk("idle_data_in", data_in, model_q);
    endtask

    task automatic reset_in_wait_r();
        bus_t b;
        b.addr = 32'h104; b.be = 4'hF; b.wdata = '0; b.we = 1'b0; b.chk_be = 1'b1; b.req_cycles = 1;
        bus_q.push_back(b);
        @(negedge clk);
        opType = OP_LD; width = 3'b010; data_addr = 32'h104;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(negedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        #1;
        chk("waitr_stall", 32'(stall), 32'd1);
        chk("waitr_req", 32'(bus.mem_req), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        opType = OP_NONE;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("post_rst_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        model_q = '0;
        chk("post_rst_load_q", data_in, 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int   stall_cnt;
        int   req_cnt;
        bus_t eb;
        res_t er;
        stall_cnt = 0;
        req_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_cnt = 0;
                req_cnt = 0;
                continue;
            end
            if (bus.mem_req) begin
                req_cnt++;
                if (bus_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
                end else begin
                    eb = bus_q[0];
                    chk("bus_addr", bus.mem_addr, eb.addr);
                    chk("bus_we", 32'(bus.mem_we), 32'(eb.we));
                    if (eb.chk_be) chk("bus_be", 32'(bus.mem_be), 32'(eb.be));
                    if (eb.we) chk("bus_wdata", bus.mem_wdata, eb.wdata);
                    if (bus.mem_gnt) begin
                        chk("req_cycles", 32'(req_cnt), 32'(eb.req_cycles));
                        void'(bus_q.pop_front());
                        req_cnt = 0;
                    end
                end
            end
            if (opType == OP_LD || opType == OP_ST) begin
                if (stall) begin
                    stall_cnt++;
                end else if (res_q.size() == 0) begin
                    chk("unexpected_completion", 32'(res_q.size()), 32'd1);
                end else begin
                    er = res_q.pop_front();
                    chk("misalign", 32'(misalign), 32'(er.mis));
                    chk("data_in", data_in, er.data);
                    chk("bus_err", 32'(bus_err), 32'(er.berr));
                    chk("stall_cycles", 32'(stall_cnt), 32'(er.stalls));
                    if (er.pop_bus) begin
                        if (bus_q.size() != 0) begin
                            chk("timeout_req_cycles", 32'(req_cnt), 32'(bus_q[0].req_cycles));
                            void'(bus_q.pop_front());
                        end
                        req_cnt = 0;
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [31:0] a, d, rdv;
        logic [1:0]  op;
        int          sel;
        rst = 1'b1;
        opType = OP_LD; width = 3'b010; data_addr = '0; data_out = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        #3;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_stall_forced", 32'(stall), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        opType = OP_NONE;
        rst = 1'b0;

        run_op(OP_LD, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
        run_op(OP_LD, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FF00);
        run_op(OP_LD, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_FF00);
        run_op(OP_ST, 3'b001, 32'h202, 32'h1234_ABCD, 3, 0, 32'h0);
        idle_cycle();
        run_op(OP_LD, 3'b010, 32'h101, 32'h0, 0, 1, 32'h1111_1111);
        idle_cycle();
        run_op(OP_LD, 3'b101, 32'h006, 32'h0, 0, 0, 32'h9ABC_1234);
        run_op(OP_ST, 3'b010, 32'h010, 32'hA5A5_5A5A, 0, 0, 32'h0);
        run_op(OP_ST, 3'b100, 32'h010, 32'h0, 0, 0, 32'h0);
        run_op(OP_LD, 3'b011, 32'h010, 32'h0, 0, 0, 32'h0);
        idle_cycle();
        reset_in_wait_r();
        idle_cycle();
`ifdef DMEM_TIMEOUT_EN
        run_op(OP_LD, 3'b010, 32'h300, 32'h0, 1000, 1, 32'h0);
        idle_cycle();
`endif
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            d = $urandom;
            rdv = $urandom;
            if (sel >= 8) begin
                idle_cycle();
            end else begin
                op = (sel < 4) ? OP_LD : OP_ST;
                run_op(op, 3'($urandom_range(0, 7)), a, d,
                       $urandom_range(0, 3), $urandom_range(0, 3), rdv);
            end
        end
        idle_cycle();
        @(negedge clk);
        #3;
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory bus controller directly downstream of the memory stage. It takes the stage's access request (opType, width, data_addr, data_out) and turns it into a req/gnt/rvalid transaction on the external data bus, with byte-lane steering for stores. It returns aligned, sign- or zero-extended load data on data_in, and holds the pipeline via stall until the access completes.

## Interface
- W, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, bus-wait limit in cycles; used only with DMEM_TIMEOUT_EN.

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- opType  input  2  2'b10 load, 2'b01 store, 2'b00/2'b11 none
- width  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- data_addr  input  W  byte address
- data_out  input  W  store data; low bits are used
- data_in  output  W  extended load result to memory stage
- stall  output  1  freezes the pipeline while high
- misalign  output  1  misaligned access or illegal width; no bus access is made
- bus_err  output  1  one-cycle pulse on timeout abort
- mem_req  output  1  bus request
- mem_we  output  1  1 = write
- mem_addr  output  W  word address, {data_addr[W-1:2], 2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  W  lane-replicated store data
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  mem_rdata is valid
- mem_rdata  input  W  read word

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, opType none: stall=0, misalign=0, data_in = load_q.
- IDLE, load/store that is legal and aligned:
  - stall=1 (combinational).
  - Latch mem_addr, mem_be, mem_wdata, mem_we, addr[1:0], width.
  - Go to REQ.
- IDLE, illegal access: misalign=1, stall=0, data_in=0, stay in IDLE. Illegal means any of:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - width 011/110/111
  - store with width[2]=1
- REQ: mem_req=1; all bus outputs are held stable until mem_gnt.
  - gnt on a store: go to DONE.
  - gnt on a load, no rvalid in the same cycle: go to WAIT_R.
  - gnt on a load with rvalid in the same cycle: capture data, go to DONE.
- WAIT_R: mem_req=0. On mem_rvalid, capture data and go to DONE.
- DONE: stall=0, data_in = load_q, go to IDLE.
  - The pipeline advances on this edge, so the same request is never reissued.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}.
  - W: be = 4'b1111, wdata = d.
- Load capture: shifted = mem_rdata >> (8*addr[1:0]).
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
  - The result is registered into load_q.
- stall is high in REQ and WAIT_R, and high in IDLE when a legal access is presented.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, load_q=0, bus_err=0.
  - stall is forced to 0 and misalign to 0 while rst is high.
- Reset mid-transaction: the FSM aborts to IDLE asynchronously and mem_req drops immediately. Any later rvalid is ignored.
- Load, gnt in first REQ cycle, rvalid one cycle later:
  - IDLE → REQ → WAIT_R → DONE.
  - 3 stall cycles; data_in is valid in the DONE cycle.
- Load, gnt and rvalid in the same cycle: 2 stall cycles.
- Store, immediate gnt: 2 stall cycles.
- Back-to-back accesses: there is always one DONE cycle between transactions. mem_req is never high in two consecutive transactions without an intervening low cycle.
- mem_rvalid outside WAIT_R, or outside a REQ cycle that has gnt, is ignored.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT: go to DONE, load_q=0, bus_err=1 for that DONE cycle, mem_req drops.
- DMEM_TIMEOUT_EN undefined:
  - There is no counter and the FSM waits indefinitely.
  - bus_err is tied to 0.

## Test plan
- LW at 0x100, gnt in the first REQ cycle, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=4'hF, stall high 3 cycles, data_in=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF_FF00 -> data_in=0xFFFFFF80. LBU at the same address -> data_in=0x00000080.
- SH at 0x202 with data_out=0x1234ABCD, gnt held off 3 cycles -> mem_addr=0x200, be=4'b1100, wdata=0xABCDABCD, all held stable over 4 REQ cycles, mem_we=1.
- LW at 0x101 -> misalign=1, mem_req never asserted, stall=0, data_in=0.
- Assert rst in WAIT_R -> mem_req=0 and state IDLE immediately; a later rvalid has no effect and load_q=0.
- DMEM_TIMEOUT_EN defined, TIMEOUT=16, gnt never given -> mem_req high 16 cycles, then bus_err=1 for one cycle, data_in=0, stall drops.
